// File: rtl/mux_sel_reg.sv
// mux_sel_reg: registered N-way selector with valid/ready flow control.
//
// A one-entry output register is loaded from a single input channel. In
// MODE 0 the channel comes from `sel`. In MODE 1 the block picks it with a
// round-robin scan that starts at an internal pointer.
//
// Parameters:
//   WIDTH  data width per channel (1..32)
//   N      number of input channels (2..16, not necessarily a power of two)
//   MODE   0 = fixed select by `sel`, 1 = round-robin among valid channels
//   SELW   derived channel-index width, clog2(N) with a minimum of 1
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   sel        channel select (MODE 0 only)
//   in_data    packed channel data, channel c at [c*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero (combinational)
//   out_data   registered selected word
//   out_ch     channel index that supplied out_data
//   out_valid  out_data/out_ch hold an undelivered word
//   out_ready  consumer accepts the word this cycle

// Per-channel slice: ready qualification and the AND-OR mux leg.
module mux_sel_reg_lane #(
  parameter int WIDTH = 5,
  parameter int SELW  = 2,
  parameter int C     = 0
) (
  input  logic             can_load,
  input  logic             cand,
  input  logic [SELW-1:0]  grant,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             xfer,
  output logic [WIDTH-1:0] gated
);
  assign ready = can_load & cand & (grant == SELW'(C));
  assign xfer  = valid & ready;
  // Only the transferring lane contributes, so the OR of all legs is the mux.
  assign gated = xfer ? data : '0;
endmodule

module mux_sel_reg #(
  parameter int WIDTH = 5,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  logic                      can_load;
  logic                      cand;
  logic [SELW-1:0]           grant;
  logic [SELW-1:0]           ptr;
  logic [N-1:0]              xfer_vec;
  logic [N-1:0][WIDTH-1:0]   gated;
  logic [WIDTH-1:0]          ld_data;
  logic                      xfer;
  int                        idx;

  // Empty, or the held word leaves this same cycle (no bubble).
  assign can_load = ~out_valid | out_ready;

  // Candidate selection. The round-robin scan runs from the farthest offset
  // down to ptr itself so the closest valid channel is the last one written.
  always_comb begin
    cand  = 1'b0;
    grant = '0;
    idx   = 0;
    if (MODE == 0) begin
      if (int'(sel) < N) begin
        cand  = 1'b1;
        grant = sel;
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (in_valid[idx]) begin
          cand  = 1'b1;
          grant = SELW'(idx);
        end
      end
    end
  end

  genvar c;
  generate
    for (c = 0; c < N; c++) begin : g_lane
      mux_sel_reg_lane #(.WIDTH(WIDTH), .SELW(SELW), .C(c)) u_lane (
        .can_load (can_load),
        .cand     (cand),
        .grant    (grant),
        .valid    (in_valid[c]),
        .data     (in_data[c*WIDTH +: WIDTH]),
        .ready    (in_ready[c]),
        .xfer     (xfer_vec[c]),
        .gated    (gated[c])
      );
    end
  endgenerate

  assign xfer = |xfer_vec;

  always_comb begin
    ld_data = '0;
    for (int i = 0; i < N; i++) ld_data = ld_data | gated[i];
  end

  // A stall (out_valid & ~out_ready) forces can_load low, so neither branch
  // fires and the held word stays frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      out_data  <= ld_data;
      out_ch    <= grant;
      out_valid <= 1'b1;
      // Wrap explicitly at N, which need not equal 2^SELW.
      if (MODE == 1) ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_sel_reg.sv
// tb_mux_sel_reg: directed bench for mux_sel_reg with three instances:
//   a: MODE 0, WIDTH 5, N 4    b: MODE 1, WIDTH 5, N 4    c: MODE 0, WIDTH 5, N 5
// Expected words ({ch, data}) are queued when a transfer is set up and
// popped when the output register shows the new word.
module tb_mux_sel_reg;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  a_sel;  logic [19:0] a_in_data; logic [3:0] a_in_valid, a_in_ready;
  logic [4:0]  a_out_data; logic [1:0] a_out_ch; logic a_out_valid, a_out_ready;
  logic [1:0]  b_sel;  logic [19:0] b_in_data; logic [3:0] b_in_valid, b_in_ready;
  logic [4:0]  b_out_data; logic [1:0] b_out_ch; logic b_out_valid, b_out_ready;
  logic [2:0]  c_sel;  logic [24:0] c_in_data; logic [4:0] c_in_valid, c_in_ready;
  logic [4:0]  c_out_data; logic [2:0] c_out_ch; logic c_out_valid, c_out_ready;

  mux_sel_reg #(.WIDTH(5), .N(4), .MODE(0)) dut_a (
    .clk(clk), .reset(reset), .sel(a_sel), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_valid(a_out_valid), .out_ready(a_out_ready));
  mux_sel_reg #(.WIDTH(5), .N(4), .MODE(1)) dut_b (
    .clk(clk), .reset(reset), .sel(b_sel), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_valid(b_out_valid), .out_ready(b_out_ready));
  mux_sel_reg #(.WIDTH(5), .N(5), .MODE(0)) dut_c (
    .clk(clk), .reset(reset), .sel(c_sel), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_ch(c_out_ch),
    .out_valid(c_out_valid), .out_ready(c_out_ready));

  int checks = 0;
  int errors = 0;
  logic [15:0] qa[$], qb[$], qc[$];
  int seq5[4] = '{3, 0, 3, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic deliver(input string tag, input logic [15:0] e, input logic v,
                         input logic [7:0] ch, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(v), 32'h1);
    chk({tag, ".ch"},    32'(ch), 32'(e[15:8]));
    chk({tag, ".data"},  32'(d),  32'(e[7:0]));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_sel = '0; a_in_data = '0; a_in_valid = '0; a_out_ready = 1'b1;
    b_sel = '0; b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b1;
    c_sel = '0; c_in_data = '0; c_in_valid = '0; c_out_ready = 1'b1;
    #2;
    chk("rst.a_valid", 32'(a_out_valid), 0);
    chk("rst.b_valid", 32'(b_out_valid), 0);
    chk("rst.c_valid", 32'(c_out_valid), 0);
    #10 reset = 1'b0;

    // Asynchronous reset while a word 1F is held and stalled.
    a_sel = 2'd0; a_in_data = {5'h00, 5'h00, 5'h00, 5'h1F}; a_in_valid = 4'b0001;
    a_out_ready = 1'b0;
    #1 chk("t1.ready_empty", 32'(a_in_ready), 32'h1);
    qa.push_back({8'd0, 8'h1F});
    cyc();
    deliver("t1.load", qa.pop_front(), a_out_valid, 8'(a_out_ch), 8'(a_out_data));
    #2 reset = 1'b1;
    #1;
    chk("t1.rst_valid", 32'(a_out_valid), 0);
    chk("t1.rst_data",  32'(a_out_data), 0);
    chk("t1.rst_ch",    32'(a_out_ch), 0);
    a_out_ready = 1'b1;
    #1 chk("t1.rst_ready", 32'(a_in_ready), 32'h1);
    a_in_valid = 4'b0000;
    #1 reset = 1'b0;

    // MODE 0 basic select.
    cyc();
    a_in_data = {5'h0A, 5'h15, 5'h02, 5'h01}; a_sel = 2'd2; a_in_valid = 4'b1111;
    #1 chk("t2.ready", 32'(a_in_ready), 32'h4);
    qa.push_back({8'd2, 8'h15});
    cyc();
    deliver("t2.word", qa.pop_front(), a_out_valid, 8'(a_out_ch), 8'(a_out_data));

    // Back-pressure for two cycles, then back-to-back reload.
    a_out_ready = 1'b0; a_sel = 2'd3;
    #1 chk("t3.stall_ready", 32'(a_in_ready), 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("t3.hold_data",  32'(a_out_data), 32'h15);
      chk("t3.hold_ch",    32'(a_out_ch), 32'h2);
      chk("t3.hold_valid", 32'(a_out_valid), 1);
      chk("t3.hold_ready", 32'(a_in_ready), 0);
    end
    a_out_ready = 1'b1;
    #1 chk("t3.resume_ready", 32'(a_in_ready), 32'h8);
    qa.push_back({8'd3, 8'h0A});
    cyc();
    deliver("t3.b2b", qa.pop_front(), a_out_valid, 8'(a_out_ch), 8'(a_out_data));
    a_in_valid = 4'b0000;
    cyc();
    chk("t3.drain_valid", 32'(a_out_valid), 0);
    chk("t3.drain_data",  32'(a_out_data), 32'h0A);

    // MODE 1 round-robin, all valid, from reset.
    #1 reset = 1'b1;
    b_in_data = {5'h13, 5'h12, 5'h11, 5'h10}; b_in_valid = 4'b1111;
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int ch;
      logic [3:0] one;
      ch = i % 4;
      one = 4'b0001 << ch;
      #1 chk("t4.ready", 32'(b_in_ready), 32'(one));
      qb.push_back({8'(ch), 8'(8'h10 + ch)});
      cyc();
      deliver("t4.rr", qb.pop_front(), b_out_valid, 8'(b_out_ch), 8'(b_out_data));
    end

    // MODE 1 sparse valid with wrap, starting from ptr = 1.
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    qb.push_back({8'd0, 8'h10});
    cyc();
    deliver("t5.first", qb.pop_front(), b_out_valid, 8'(b_out_ch), 8'(b_out_data));
    b_in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      int ch;
      logic [3:0] one;
      ch = seq5[i];
      one = 4'b0001 << ch;
      #1 chk("t5.ready", 32'(b_in_ready), 32'(one));
      qb.push_back({8'(ch), 8'(8'h10 + ch)});
      cyc();
      deliver("t5.sparse", qb.pop_front(), b_out_valid, 8'(b_out_ch), 8'(b_out_data));
    end
    b_in_valid = 4'b0000;
    #1 chk("t5.idle_ready", 32'(b_in_ready), 0);
    cyc();
    chk("t5.drain_valid", 32'(b_out_valid), 0);
    cyc();
    chk("t5.idle_valid", 32'(b_out_valid), 0);
    b_in_valid = 4'b1111;
    #1 chk("t5.ptr_held", 32'(b_in_ready), 32'h2);
    qb.push_back({8'd1, 8'h11});
    cyc();
    deliver("t5.resume", qb.pop_front(), b_out_valid, 8'(b_out_ch), 8'(b_out_data));
    b_in_valid = 4'b0000;

    // MODE 0 with N = 5: top legal select, then out-of-range selects.
    c_in_data = {5'h1C, 5'h1B, 5'h1A, 5'h19, 5'h18}; c_in_valid = 5'b11111; c_sel = 3'd4;
    #1 chk("t6.ready_sel4", 32'(c_in_ready), 32'h10);
    qc.push_back({8'd4, 8'h1C});
    cyc();
    deliver("t6.sel4", qc.pop_front(), c_out_valid, 8'(c_out_ch), 8'(c_out_data));
    for (int s = 7; s >= 5; s--) begin
      c_sel = 3'(s);
      #1 chk("t6.oor_ready", 32'(c_in_ready), 0);
      cyc();
      chk("t6.oor_valid", 32'(c_out_valid), 0);
      chk("t6.oor_data",  32'(c_out_data), 32'h1C);
    end

    chk("end.queues_empty", 32'(qa.size() + qb.size() + qc.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
